// File: rtl/excpt_pkg.sv
// rtl/excpt_pkg.sv - shared types and constants for the exception sequencer
package excpt_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EPC  = 3'd1,
    ST_ADDR = 3'd2,
    ST_LOAD = 3'd3,
    ST_JUMP = 3'd4
  } state_t;

  // Cause codes reported on the cause output
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_INVOP = 2'd1;
  localparam logic [1:0] CAUSE_OVF   = 2'd2;
  localparam logic [1:0] CAUSE_DIV0  = 2'd3;

  // ALU operation used to form PC-4
  localparam logic [2:0] ALU_SUB = 3'b010;

  // Default build parameters and mux select codes
  localparam int          MEM_WAIT_DEF   = 2;
  localparam logic [31:0] VEC_INVOP_DEF  = 32'd253;
  localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
  localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;
  localparam logic [2:0]  IORD_EXCPT_DEF = 3'd3;
  localparam logic [1:0]  SRCA_PC_DEF    = 2'd0;
  localparam logic [1:0]  SRCB_FOUR_DEF  = 2'd1;
  localparam logic [2:0]  PCSRC_VEC_DEF  = 3'd6;

  // Wait counter width covers MEM_WAIT up to 7
  localparam int CNT_W = 3;

endpackage

// File: rtl/excpt_ctrl_if.sv
// rtl/excpt_ctrl_if.sv - event inputs and datapath override outputs of the exception sequencer
interface excpt_ctrl_if;
  logic        invop_evt;
  logic        ovf_evt;
  logic        div0_evt;
  logic [31:0] mem_data;
  logic        busy;
  logic [31:0] excpt_addr;
  logic [2:0]  iord;
  logic        mem_wr;
  logic [1:0]  alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  aluctrl;
  logic        epc_write;
  logic [2:0]  pcsource;
  logic        pc_write;
  logic [31:0] pc_target;
  logic [1:0]  cause;
  logic        done;
  logic        double_fault;

  // Control unit / memory side
  modport master (
    output invop_evt, ovf_evt, div0_evt, mem_data,
    input  busy, excpt_addr, iord, mem_wr, alusrca, alusrcb, aluctrl,
           epc_write, pcsource, pc_write, pc_target, cause, done, double_fault
  );

  // Exception sequencer side
  modport slave (
    input  invop_evt, ovf_evt, div0_evt, mem_data,
    output busy, excpt_addr, iord, mem_wr, alusrca, alusrcb, aluctrl,
           epc_write, pcsource, pc_write, pc_target, cause, done, double_fault
  );
endinterface

// File: rtl/excpt_prio_enc.sv
// rtl/excpt_prio_enc.sv - fixed-priority encoder from event pulses to cause and vector address
module excpt_prio_enc
  import excpt_pkg::*;
#(
  parameter logic [31:0] VEC_INVOP = VEC_INVOP_DEF,
  parameter logic [31:0] VEC_OVF   = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0  = VEC_DIV0_DEF
) (
  input  logic        i_invop,
  input  logic        i_ovf,
  input  logic        i_div0,
  output logic        o_valid,
  output logic [1:0]  o_cause,
  output logic [31:0] o_vec
);

  // Invalid opcode wins, then divide-by-zero, then overflow; losers are dropped
  always_comb begin
    o_valid = 1'b1;
    o_cause = CAUSE_NONE;
    o_vec   = 32'd0;
    if (i_invop) begin
      o_cause = CAUSE_INVOP;
      o_vec   = VEC_INVOP;
    end else if (i_div0) begin
      o_cause = CAUSE_DIV0;
      o_vec   = VEC_DIV0;
    end else if (i_ovf) begin
      o_cause = CAUSE_OVF;
      o_vec   = VEC_OVF;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/excpt_ctrl.sv
// rtl/excpt_ctrl.sv - exception sequencer: saves PC-4 to EPC, fetches vector byte, jumps to handler
module excpt_ctrl
  import excpt_pkg::*;
#(
  parameter int          MEM_WAIT   = MEM_WAIT_DEF,
  parameter logic [31:0] VEC_INVOP  = VEC_INVOP_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF,
  parameter logic [2:0]  IORD_EXCPT = IORD_EXCPT_DEF,
  parameter logic [1:0]  SRCA_PC    = SRCA_PC_DEF,
  parameter logic [1:0]  SRCB_FOUR  = SRCB_FOUR_DEF,
  parameter logic [2:0]  PCSRC_VEC  = PCSRC_VEC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  excpt_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;
  logic [31:0]      r_excpt_addr;
  logic [31:0]      r_pc_target;
  logic             r_double_fault;

  logic             w_evt_valid;
  logic             w_evt_any;
  logic [1:0]       w_evt_cause;
  logic [31:0]      w_evt_vec;

  assign w_evt_any = bus.invop_evt | bus.ovf_evt | bus.div0_evt;

  excpt_prio_enc #(
    .VEC_INVOP (VEC_INVOP),
    .VEC_OVF   (VEC_OVF),
    .VEC_DIV0  (VEC_DIV0)
  ) u_prio_enc (
    .i_invop (bus.invop_evt),
    .i_ovf   (bus.ovf_evt),
    .i_div0  (bus.div0_evt),
    .o_valid (w_evt_valid),
    .o_cause (w_evt_cause),
    .o_vec   (w_evt_vec)
  );

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and override outputs decoded purely from the current state
  always_comb begin
    w_next        = r_state;
    bus.iord      = 3'd0;
    bus.mem_wr    = 1'b0;
    bus.alusrca   = 2'd0;
    bus.alusrcb   = 2'd0;
    bus.aluctrl   = 3'd0;
    bus.epc_write = 1'b0;
    bus.pcsource  = 3'd0;
    bus.pc_write  = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_evt_valid) w_next = ST_EPC;
      end
      ST_EPC: begin
        bus.alusrca   = SRCA_PC;
        bus.alusrcb   = SRCB_FOUR;
        bus.aluctrl   = ALU_SUB;
        bus.epc_write = 1'b1;
        w_next        = ST_ADDR;
      end
      ST_ADDR: begin
        bus.iord = IORD_EXCPT;
        if (r_cnt == '0) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.iord = IORD_EXCPT;
        w_next   = ST_JUMP;
      end
      ST_JUMP: begin
        bus.pcsource = PCSRC_VEC;
        bus.pc_write = 1'b1;
        bus.done     = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Memory wait counter: loaded on leaving EPC so ADDR lasts MEM_WAIT+1 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_cnt <= '0;
    else if (r_state == ST_EPC)               r_cnt <= WAIT_LOAD;
    else if (r_state == ST_ADDR && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Cause/vector latched on acceptance, handler byte captured at the end of LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cause      <= CAUSE_NONE;
      r_excpt_addr <= 32'd0;
      r_pc_target  <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && w_evt_valid) begin
        r_cause      <= w_evt_cause;
        r_excpt_addr <= w_evt_vec;
      end
      if (r_state == ST_LOAD) r_pc_target <= {24'd0, bus.mem_data[7:0]};
    end
  end

  // Sticky flag for events that arrive while a sequence is running
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_double_fault <= 1'b0;
    else if (r_state != ST_IDLE && w_evt_any)  r_double_fault <= 1'b1;
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.excpt_addr   = r_excpt_addr;
  assign bus.pc_target    = r_pc_target;
  assign bus.cause        = r_cause;
  assign bus.double_fault = r_double_fault;

endmodule

// File: tb/tb_excpt_ctrl.sv
// tb/tb_excpt_ctrl.sv - randomized self-checking bench for excpt_ctrl (MEM_WAIT=2 and MEM_WAIT=0 builds)
module tb_excpt_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  excpt_ctrl_if bus0 ();
  excpt_ctrl_if bus1 ();

  excpt_ctrl #(.MEM_WAIT(2)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  excpt_ctrl #(.MEM_WAIT(0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference model: each DUT's progress is the distance from the edge that accepted its event
  int          mw [2] = '{2, 0};
  int          t0 [2];
  logic [1:0]  m_cause [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_pct [2];
  logic        m_df [2];
  int          edge_n;

  function automatic bit is_busy(input int k, input int w);
    return (k >= 1) && (k <= w + 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t0[i] = -1000; m_cause[i] = 2'd0; m_addr[i] = 32'd0; m_pct[i] = 32'd0; m_df[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit inv, input bit ovf, input bit dz, input logic [7:0] md);
    for (int i = 0; i < 2; i++) begin
      int kprev;
      kprev = edge_n - t0[i];
      if (kprev == mw[i] + 3) m_pct[i] = {24'd0, md};
      if (inv || ovf || dz) begin
        if (is_busy(kprev, mw[i])) m_df[i] = 1'b1;
        else begin
          t0[i] = edge_n;
          if (inv)     begin m_cause[i] = 2'd1; m_addr[i] = 32'd253; end
          else if (dz) begin m_cause[i] = 2'd3; m_addr[i] = 32'd255; end
          else         begin m_cause[i] = 2'd2; m_addr[i] = 32'd254; end
        end
      end
    end
  endtask

  task automatic check_dut(input int i);
    logic        o_busy, o_done, o_df;
    logic [15:0] o_ctrl, e_ctrl;
    logic [31:0] o_addr, o_pct;
    logic [1:0]  o_cause;
    logic [2:0]  e_iord, e_aluctrl, e_pcsrc;
    logic [1:0]  e_srca, e_srcb;
    logic        e_epcw, e_pcw;
    int          k, w;
    if (i == 0) begin
      o_busy = bus0.busy; o_done = bus0.done; o_df = bus0.double_fault;
      o_addr = bus0.excpt_addr; o_pct = bus0.pc_target; o_cause = bus0.cause;
      o_ctrl = {bus0.iord, bus0.mem_wr, bus0.alusrca, bus0.alusrcb, bus0.aluctrl,
                bus0.epc_write, bus0.pcsource, bus0.pc_write};
    end else begin
      o_busy = bus1.busy; o_done = bus1.done; o_df = bus1.double_fault;
      o_addr = bus1.excpt_addr; o_pct = bus1.pc_target; o_cause = bus1.cause;
      o_ctrl = {bus1.iord, bus1.mem_wr, bus1.alusrca, bus1.alusrcb, bus1.aluctrl,
                bus1.epc_write, bus1.pcsource, bus1.pc_write};
    end
    k = edge_n - t0[i] + 1;
    w = mw[i];
    e_iord = 3'd0; e_srca = 2'd0; e_srcb = 2'd0; e_aluctrl = 3'd0;
    e_epcw = 1'b0; e_pcsrc = 3'd0; e_pcw = 1'b0;
    if (k == 1) begin e_srca = 2'd0; e_srcb = 2'd1; e_aluctrl = 3'b010; e_epcw = 1'b1; end
    if (k >= 2 && k <= w + 3) e_iord = 3'd3;
    if (k == w + 4) begin e_pcsrc = 3'd6; e_pcw = 1'b1; end
    e_ctrl = {e_iord, 1'b0, e_srca, e_srcb, e_aluctrl, e_epcw, e_pcsrc, e_pcw};
    chk($sformatf("d%0d e%0d busy", i, edge_n), 64'(o_busy), 64'(is_busy(k, w)));
    chk($sformatf("d%0d e%0d ctrl", i, edge_n), 64'(o_ctrl), 64'(e_ctrl));
    chk($sformatf("d%0d e%0d done", i, edge_n), 64'(o_done), 64'(k == w + 4));
    chk($sformatf("d%0d e%0d excpt_addr", i, edge_n), 64'(o_addr), 64'(m_addr[i]));
    chk($sformatf("d%0d e%0d cause", i, edge_n), 64'(o_cause), 64'(m_cause[i]));
    chk($sformatf("d%0d e%0d pc_target", i, edge_n), 64'(o_pct), 64'(m_pct[i]));
    chk($sformatf("d%0d e%0d double_fault", i, edge_n), 64'(o_df), 64'(m_df[i]));
  endtask

  // Drive inputs at the falling edge, clock once, update model, check at the next falling edge
  task automatic step(input bit inv, input bit ovf, input bit dz, input logic [7:0] md);
    logic [31:0] mdw;
    mdw = {$urandom_range(0, 32'hFFFFFF), md};
    bus0.invop_evt = inv; bus0.ovf_evt = ovf; bus0.div0_evt = dz; bus0.mem_data = mdw;
    bus1.invop_evt = inv; bus1.ovf_evt = ovf; bus1.div0_evt = dz; bus1.mem_data = mdw;
    @(posedge clk);
    edge_n++;
    model_edge(inv, ovf, dz, md);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic idle(input int n, input logic [7:0] md);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, md);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " d0 outs"}, {bus0.busy, bus0.iord, bus0.alusrca, bus0.alusrcb, bus0.aluctrl,
        bus0.epc_write, bus0.pcsource, bus0.pc_write, bus0.done, bus0.cause, bus0.double_fault},
        64'd0);
    chk({tag, " d0 addr/target"}, {bus0.excpt_addr, bus0.pc_target}, 64'd0);
    chk({tag, " d1 outs"}, {bus1.busy, bus1.iord, bus1.alusrca, bus1.alusrcb, bus1.aluctrl,
        bus1.epc_write, bus1.pcsource, bus1.pc_write, bus1.done, bus1.cause, bus1.double_fault},
        64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus0.invop_evt = 0; bus0.ovf_evt = 0; bus0.div0_evt = 0; bus0.mem_data = 0;
    bus1.invop_evt = 0; bus1.ovf_evt = 0; bus1.div0_evt = 0; bus1.mem_data = 0;
    edge_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Overflow sampled at edge 10 with handler byte 0x40
    idle(9, 8'h40);
    step(1'b0, 1'b1, 1'b0, 8'h40);
    idle(8, 8'h40);

    // Simultaneous invop and overflow: invop wins, no double fault
    step(1'b1, 1'b1, 1'b0, 8'h12);
    idle(8, 8'h12);

    // Divide-by-zero then overflow two cycles later: the latter sets double_fault
    step(1'b0, 1'b0, 1'b1, 8'h77);
    idle(1, 8'h77);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    idle(8, 8'h77);

    // Top bit set in vector byte must not sign-extend
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    idle(8, 8'hFF);

    // Asynchronous reset while both builds sit in ADDR
    step(1'b1, 1'b0, 1'b0, 8'h55);
    idle(1, 8'h55);
    chk("pre-reset d0 iord", 64'(bus0.iord), 64'd3);
    #1 reset = 1'b1;
    #1 check_zero("async reset");
    @(posedge clk);
    edge_n++;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(8, 8'h55);

    // Randomized event traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)));
    end
    idle(8, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/excpt_ctrl.md
Name: excpt_ctrl

Overview:
- Exception sequencer for the multicycle datapath.
- Accepts single-cycle exception events from the main control unit: invalid opcode, overflow, divide-by-zero.
- Picks one by fixed priority, then takes over datapath control to:
  - save PC-4 into EPC
  - fetch the handler address byte from the fixed vector location
  - load PC with that byte, zero-extended
- While busy, its control outputs replace those of the main control unit through the top-level override mux.

Parameters:
MEM_WAIT, 2, cycles the memory address is held before read data is valid (0..7)
VEC_INVOP, 32'd253, vector byte address for invalid opcode
VEC_OVF, 32'd254, vector byte address for overflow
VEC_DIV0, 32'd255, vector byte address for divide-by-zero
IORD_EXCPT, 3'd3, IorD select code routing excpt_addr to memory
SRCA_PC, 2'd0, ALUSrcA code selecting PC
SRCB_FOUR, 2'd1, ALUSrcB code selecting constant 4
PCSRC_VEC, 3'd6, PCSource code selecting pc_target

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
invop_evt  in  1  invalid-opcode pulse from the control unit
ovf_evt  in  1  overflow pulse (Ofw already qualified by the control unit)
div0_evt  in  1  divide-by-zero pulse
mem_data  in  32  memory read data; only bits [7:0] are used
busy  out  1  override active; control unit must stall
excpt_addr  out  32  address presented to the Excpt input of the IorD mux
iord  out  3  IorD override
mem_wr  out  1  memory write override; always 0
alusrca  out  2  ALUSrcA override
alusrcb  out  2  ALUSrcB override
aluctrl  out  3  ALU op override
epc_write  out  1  EPC load enable (EPC input = ALU result)
pcsource  out  3  PCSource override
pc_write  out  1  PC load enable
pc_target  out  32  zero-extended vector byte
cause  out  2  last serviced cause: 0 none, 1 invop, 2 ovf, 3 div0
done  out  1  one-cycle pulse when the handler jump is issued
double_fault  out  1  sticky: an event arrived while busy

Behaviour:
- Reset: clk and reset as described above. All outputs go to 0, state goes to IDLE, and cause, pc_target, counter and double_fault clear. Reset mid-sequence aborts immediately; no PC or EPC write completes afterwards.
- Outputs:
  - All control outputs are registered or decoded purely from state.
  - In IDLE every control output is 0.
  - busy = (state != IDLE).
- Priority: invop > div0 > ovf.
  - Simultaneous events: only the highest is serviced; the others are dropped.
- States:
  - IDLE: wait for any event.
    - On the clock edge where any event is high: latch cause and excpt_addr, go to EPC.
  - EPC (1 cycle): drive alusrca=SRCA_PC, alusrcb=SRCB_FOUR, aluctrl=3'b010 (sub) and epc_write=1, so EPC receives PC-4.
    - Then go to ADDR with counter=MEM_WAIT.
  - ADDR (MEM_WAIT+1 cycles): drive iord=IORD_EXCPT with mem_wr=0.
    - Counter decrements each cycle; at 0 go to LOAD.
  - LOAD (1 cycle): keep iord held.
    - Capture pc_target = {24'b0, mem_data[7:0]}.
  - JUMP (1 cycle): drive pcsource=PCSRC_VEC and pc_write=1, and pulse done=1.
    - Then go to IDLE.
- Latency: with the event sampled at edge N, busy is high for cycles N+1 .. N+MEM_WAIT+4.
  - Default MEM_WAIT=2 gives 6 busy cycles.
- Events while busy:
  - Not serviced and not queued.
  - Set double_fault, which holds until reset.
- excpt_addr and cause stay stable from EPC through JUMP and retain their value in IDLE.
- MEM_WAIT=0: ADDR lasts exactly 1 cycle.

Decomposition:
- Shared package excpt_pkg holds:
  - state encoding (IDLE, EPC, ADDR, LOAD, JUMP)
  - cause codes
  - ALU op constants (SUB=3'b010)
  - the mux select defaults
- One sub-module, excpt_prio_enc: combinational priority encoder mapping {invop, div0, ovf} to cause and vector address.

Test Plan:
- ovf_evt pulse at cycle 10, mem_data[7:0]=8'h40, default params:
  - cycle 11: epc_write=1, aluctrl=010, alusrcb=SRCB_FOUR
  - cycles 12-14: iord=3, excpt_addr=254
  - cycle 16: pc_write=1, done=1, pc_target=32'h40
  - cause=2; busy high for exactly cycles 11-16
- invop_evt and ovf_evt in the same cycle -> cause=1, excpt_addr=253, double_fault stays 0.
- div0_evt, then ovf_evt two cycles later:
  - sequence completes with cause=3, excpt_addr=255
  - double_fault=1 and remains 1 after return to IDLE
- reset asserted asynchronously during ADDR -> all outputs 0 within the same cycle, no pc_write/epc_write afterwards, state IDLE after release.
- mem_data[7:0]=8'hFF -> pc_target=32'h000000FF (zero-extended, not sign-extended).
- MEM_WAIT=0 build with ovf_evt -> busy for exactly 4 cycles and ADDR lasts 1 cycle.
